transpose_switch_stage: RTL and testbench

TRANSPOSE_SWITCH_STAGE -- requirements
Module: transpose_switch_stage

---
 rtl/transpose_pkg.sv | 21 ++
 rtl/swap_mux.sv | 27 ++
 rtl/transpose_switch_stage.sv | 127 ++++++++++++
 tb/tb_transpose_switch_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/transpose_pkg.sv
// rtl/transpose_pkg.sv - shared types and defaults for the transpose switch stage
package transpose_pkg;

  localparam int ELEM_W_DEF    = 8;
  localparam int NUM_ELEM_DEF  = 4;
  localparam int BLK_DEF       = 2;
  localparam int FRAME_LEN_DEF = 4;

  typedef logic [ELEM_W_DEF-1:0] elem_t;

  typedef enum logic {
    MODE_PASS = 1'b0,
    MODE_SWAP = 1'b1
  } mode_e;

  // True for lanes in the upper half of a swap block pair (lane bit BLK set).
  function automatic logic is_upper(input int idx, input int blk);
    return (idx & blk) != 0;
  endfunction

endpackage

// File: rtl/swap_mux.sv
// rtl/swap_mux.sv - per-lane lo/hi selector for block swap or pass-through
module swap_mux
  import transpose_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF
) (
  input  mode_e             mode,
  input  logic              upper,
  input  logic [ELEM_W-1:0] a_self,
  input  logic [ELEM_W-1:0] a_partner,
  input  logic [ELEM_W-1:0] b_self,
  input  logic [ELEM_W-1:0] b_partner,
  output logic [ELEM_W-1:0] lo,
  output logic [ELEM_W-1:0] hi
);

  // Lower lanes pull the partner A element into hi; upper lanes pull the partner B element into lo.
  always_comb begin
    lo = a_self;
    hi = b_self;
    if (mode == MODE_SWAP) begin
      if (upper) lo = b_partner;
      else       hi = a_partner;
    end
  end

endmodule

// File: rtl/transpose_switch_stage.sv
// rtl/transpose_switch_stage.sv - frame-moded block swap stage with 2-entry output buffer
module transpose_switch_stage
  import transpose_pkg::*;
#(
  parameter int ELEM_W    = ELEM_W_DEF,
  parameter int NUM_ELEM  = NUM_ELEM_DEF,
  parameter int BLK       = BLK_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ctrl,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_ELEM-1:0][ELEM_W-1:0]  in_elements_down,
  input  logic [NUM_ELEM-1:0][ELEM_W-1:0]  in_elements_across,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_ELEM-1:0][ELEM_W-1:0]  out_lo,
  output logic [NUM_ELEM-1:0][ELEM_W-1:0]  out_hi,
  output logic                             out_last
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [CNT_W-1:0]                 beat_cnt;
  mode_e                            mode_q;
  mode_e                            cur_mode;
  logic                             beat_last;
  logic                             push;
  logic                             pop;
  logic [1:0]                       occ;
  logic [1:0]                       occ_next;
  logic [NUM_ELEM-1:0][ELEM_W-1:0]  mux_lo;
  logic [NUM_ELEM-1:0][ELEM_W-1:0]  mux_hi;
  logic [NUM_ELEM-1:0][ELEM_W-1:0]  skid_lo;
  logic [NUM_ELEM-1:0][ELEM_W-1:0]  skid_hi;
  logic                             skid_last;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign cur_mode  = (beat_cnt == '0) ? mode_e'(ctrl) : mode_q;
  assign beat_last = (beat_cnt == CNT_W'(FRAME_LEN - 1));

  for (genvar i = 0; i < NUM_ELEM; i++) begin : g_lane
    swap_mux #(
      .ELEM_W(ELEM_W)
    ) u_swap_mux (
      .mode      (cur_mode),
      .upper     (is_upper(i, BLK)),
      .a_self    (in_elements_down[i]),
      .a_partner (in_elements_down[i ^ BLK]),
      .b_self    (in_elements_across[i]),
      .b_partner (in_elements_across[i ^ BLK]),
      .lo        (mux_lo[i]),
      .hi        (mux_hi[i])
    );
  end

  // Frame position and the mode captured on the first beat of each frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      mode_q   <= MODE_PASS;
    end else if (push) begin
      if (beat_cnt == '0) mode_q <= cur_mode;
      beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
    end
  end

  // Occupancy after this cycle's push/pop; feeds the registered handshake flags.
  always_comb begin
    occ_next = occ;
    if (push && !pop)      occ_next = occ + 2'd1;
    else if (pop && !push) occ_next = occ - 2'd1;
  end

  // Head register drives the outputs directly; the skid entry absorbs one beat of backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ       <= 2'd0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_lo    <= '0;
      out_hi    <= '0;
      out_last  <= 1'b0;
      skid_lo   <= '0;
      skid_hi   <= '0;
      skid_last <= 1'b0;
    end else begin
      occ       <= occ_next;
      in_ready  <= (occ_next < 2'd2);
      out_valid <= (occ_next != 2'd0);
      unique case (occ)
        2'd0: begin
          if (push) begin
            out_lo   <= mux_lo;
            out_hi   <= mux_hi;
            out_last <= beat_last;
          end
        end
        2'd1: begin
          if (push && pop) begin
            out_lo   <= mux_lo;
            out_hi   <= mux_hi;
            out_last <= beat_last;
          end else if (push) begin
            skid_lo   <= mux_lo;
            skid_hi   <= mux_hi;
            skid_last <= beat_last;
          end
        end
        2'd2: begin
          if (pop) begin
            out_lo   <= skid_lo;
            out_hi   <= skid_hi;
            out_last <= skid_last;
          end
        end
        default: begin
          out_lo <= out_lo;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transpose_switch_stage.sv
// tb/tb_transpose_switch_stage.sv - self-checking bench for transpose_switch_stage
module tb_transpose_switch_stage;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int BLK = 2;
  localparam int FL  = 4;

  typedef logic [N-1:0][W-1:0] vec_t;
  typedef struct packed {
    vec_t lo;
    vec_t hi;
    logic last;
  } beat_t;

  localparam vec_t A_LIT   = 32'h3C2C0B0C;
  localparam vec_t B_LIT   = 32'h3D1C1D0D;
  localparam vec_t SWAP_LO = 32'h1D0D0B0C;
  localparam vec_t SWAP_HI = 32'h3D1C3C2C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ctrl = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  vec_t a = '0;
  vec_t b = '0;
  logic in_ready;
  logic out_valid;
  logic out_last;
  vec_t out_lo;
  vec_t out_hi;

  int total = 0;
  int bad = 0;

  beat_t q[$];
  vec_t  lo_log[$];
  int    pop_cyc[$];
  int    m_cnt;
  logic  m_mode;
  logic  m_ready_en;
  int    n_in;
  int    n_out;
  int    cyc = 0;
  logic [31:0] last_bits;

  transpose_switch_stage #(
    .ELEM_W(W), .NUM_ELEM(N), .BLK(BLK), .FRAME_LEN(FL)
  ) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_elements_down(a), .in_elements_across(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lo(out_lo), .out_hi(out_hi), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference: frames of FL beats, mode from beat 0, swap by block rule, FIFO as a queue.
  always @(posedge clk or posedge rst) begin : model
    beat_t h;
    beat_t p;
    logic  md;
    if (rst) begin
      q.delete(); lo_log.delete(); pop_cyc.delete();
      m_cnt = 0; m_mode = 0; m_ready_en = 0;
      n_in = 0; n_out = 0; last_bits = '0;
    end else begin
      cyc++;
      if (out_valid && out_ready && q.size() != 0) begin
        h = q.pop_front();
        lo_log.push_back(h.lo);
        pop_cyc.push_back(cyc);
        if (n_out < 32) last_bits[n_out] = h.last;
        n_out++;
      end
      if (in_valid && in_ready) begin
        md = (m_cnt == 0) ? ctrl : m_mode;
        if (m_cnt == 0) m_mode = ctrl;
        for (int i = 0; i < N; i++) begin
          if (md && ((i & BLK) == 0)) begin
            p.lo[i] = a[i];       p.hi[i] = a[i + BLK];
          end else if (md) begin
            p.lo[i] = b[i - BLK]; p.hi[i] = b[i];
          end else begin
            p.lo[i] = a[i];       p.hi[i] = b[i];
          end
        end
        p.last = (m_cnt == FL - 1);
        m_cnt = (m_cnt + 1) % FL;
        q.push_back(p);
        n_in++;
      end
      m_ready_en = 1;
    end
  end

  // Per-cycle comparison of handshake and head-of-queue data.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", 64'(in_ready), 64'(m_ready_en && q.size() < 2));
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        check("out_lo", 64'(out_lo), 64'(q[0].lo));
        check("out_hi", 64'(out_hi), 64'(q[0].hi));
        check("out_last", 64'(out_last), 64'(q[0].last));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_lo", 64'(out_lo), 64'd0);
    check("rst_out_hi", 64'(out_hi), 64'd0);
    step();
    step();
    rst = 1'b0;
    check("rdy_low_after_rel", 64'(in_ready), 64'd0);
    step();
    check("rdy_rise", 64'(in_ready), 64'd1);
  endtask

  initial begin
    // Swap literal
    do_reset();
    a = A_LIT; b = B_LIT; ctrl = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("swap_valid", 64'(out_valid), 64'd1);
    check("swap_lo", 64'(out_lo), 64'(SWAP_LO));
    check("swap_hi", 64'(out_hi), 64'(SWAP_HI));
    step();

    // Pass-through literal
    do_reset();
    a = A_LIT; b = B_LIT; ctrl = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("pass_lo", 64'(out_lo), 64'(A_LIT));
    check("pass_hi", 64'(out_hi), 64'(B_LIT));
    step();

    // Mid-frame ctrl change ignored
    do_reset();
    out_ready = 1'b1; a = A_LIT; b = B_LIT;
    for (int k = 0; k < 5; k++) begin
      ctrl = (k == 0);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step(); step();
    check("mid_nout", 64'(n_out), 64'd5);
    check("mid_last", 64'(last_bits[4:0]), 64'(5'b01000));
    check("mid_beat4", 64'(lo_log.size() > 3 ? lo_log[3] : '0), 64'(SWAP_LO));
    check("mid_beat5", 64'(lo_log.size() > 4 ? lo_log[4] : '0), 64'(A_LIT));

    // Backpressure
    do_reset();
    out_ready = 1'b0; ctrl = 1'b0; b = '0;
    for (int k = 0; k < 3; k++) begin
      a = vec_t'(n_in + 1);
      in_valid = 1'b1;
      step();
    end
    check("bp_accepted", 64'(n_in), 64'd2);
    check("bp_ready_low", 64'(in_ready), 64'd0);
    check("bp_frozen", 64'(out_lo[0]), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 10 && n_in < 3; k++) begin
      a = vec_t'(n_in + 1);
      step();
    end
    in_valid = 1'b0;
    check("bp_third_in", 64'(n_in), 64'd3);
    for (int k = 0; k < 4; k++) step();
    check("bp_nout", 64'(n_out), 64'd3);
    for (int k = 0; k < 3; k++)
      check("bp_order", 64'(lo_log.size() > k ? lo_log[k][0] : '0), 64'(k + 1));

    // Reset mid-operation
    do_reset();
    out_ready = 1'b0; ctrl = 1'b0; a = 32'h11111111; b = 32'h22222222;
    in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_lo", 64'(out_lo), 64'd0);
    step();
    rst = 1'b0;
    step();
    out_ready = 1'b1; a = A_LIT; b = B_LIT;
    for (int k = 0; k < 4; k++) begin
      ctrl = (k == 0);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step(); step();
    check("midrst_last", 64'(last_bits[3:0]), 64'(4'b1000));
    check("midrst_first", 64'(lo_log.size() > 0 ? lo_log[0] : '0), 64'(SWAP_LO));

    // Throughput
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a = vec_t'($urandom); b = vec_t'($urandom); ctrl = 1'($urandom);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step(); step();
    check("tp_nin", 64'(n_in), 64'd8);
    check("tp_nout", 64'(n_out), 64'd8);
    check("tp_last", 64'(last_bits[7:0]), 64'(8'b10001000));
    check("tp_consec", 64'(pop_cyc.size() == 8 ? pop_cyc[7] - pop_cyc[0] : -1), 64'd7);

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 800; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ctrl = 1'($urandom);
      a = vec_t'($urandom);
      b = vec_t'($urandom);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("rand_drained", 64'(q.size()), 64'd0);
    check("rand_inout", 64'(n_out), 64'(n_in));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
